mem_access_unit: RTL

- Multi-cycle load/store stage between the EX/MEM and MEM/WB pipeline registers.
- Handles word, halfword and byte accesses with sign or zero extension of loads.
- Runs a request/acknowledge handshake with a variable-latency data bus and requests a pipeline stall while an access is outstanding.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit_pkg.sv | 50 +++++
 rtl/mem_access_unit_lane.sv | 60 ++++++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared op codes, FSM encoding and op-decoding helpers for the load/store stage.
package mem_access_unit_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    // log2 of the access size in bytes
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_unsigned_load(input logic [7:0] op);
        return (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
    endfunction

    function automatic logic [1:0] access_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SIZE_B;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane steering: byte enables, store replication, load extraction, alignment.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1
) (
    input  logic [7:0]                    op,
    input  logic [$clog2(DATA_W/8)-1:0]   offset,
    input  logic [DATA_W-1:0]             reg2,
    input  logic [DATA_W-1:0]             bus_data,
    output logic [DATA_W/8-1:0]           sel,
    output logic [DATA_W-1:0]             store_data,
    output logic [DATA_W-1:0]             load_data,
    output logic                          misalign
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic [1:0]        size;
    logic [OFF_W-1:0]  mask;
    logic [OFF_W-1:0]  base;
    logic [OFF_W-1:0]  lo;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        size = access_size(op);
        case (size)
            SIZE_B:  mask = '0;
            SIZE_H:  mask = OFF_W'(1);
            default: mask = OFF_W'(3);
        endcase
        base     = offset & ~mask;
        misalign = |(offset & mask);
        // Big-endian lowest lane of the group is NB-1-(base+mask), i.e. the complement.
        lo       = BIG_ENDIAN ? ~(base | mask) : base;
        shifted  = bus_data >> {lo, 3'b000};

        case (size)
            SIZE_B: begin
                sel        = NB'(1) << lo;
                store_data = {NB{reg2[7:0]}};
                load_data  = is_unsigned_load(op) ? DATA_W'(shifted[7:0])
                                                  : DATA_W'($signed(shifted[7:0]));
            end
            SIZE_H: begin
                sel        = NB'(3) << lo;
                store_data = {(NB/2){reg2[15:0]}};
                load_data  = is_unsigned_load(op) ? DATA_W'(shifted[15:0])
                                                  : DATA_W'($signed(shifted[15:0]));
            end
            default: begin
                sel        = NB'(15) << lo;
                store_data = {(NB/4){reg2[31:0]}};
                load_data  = DATA_W'($signed(shifted[31:0]));
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage with ack handshake, stall request, misalign and timeout detection.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter bit BIG_ENDIAN  = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [7:0]            aluop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [DATA_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_sel_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic                  mem_ce_o,
    output logic                  stallreq_o,
    output logic                  adel_o,
    output logic                  ades_o,
    output logic                  buserr_o,
    output logic [ADDR_W-1:0]     badaddr_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              err;

    logic [ADDR_W-1:0]     addr_p1;
    logic [NB-1:0]         sel_p1;
    logic [DATA_W-1:0]     sdata_p1;
    logic [DATA_W-1:0]     ldata_p1;
    logic [7:0]            op_p1;
    logic [REG_ADDR_W-1:0] wd_p1;
    logic                  wreg_p1;

    logic              in_access, is_mem, start, timeout_hit;
    logic [7:0]        lane_op;
    logic [OFF_W-1:0]  lane_off;
    logic [NB-1:0]     lane_sel;
    logic [DATA_W-1:0] lane_sdata, lane_ldata;
    logic              lane_misalign;

    assign in_access   = (state == ACCESS);
    // The aligner decodes the incoming request in IDLE and the latched one while waiting for ack.
    assign lane_op     = in_access ? op_p1 : aluop_i;
    assign lane_off    = in_access ? addr_p1[OFF_W-1:0] : mem_addr_i[OFF_W-1:0];
    assign is_mem      = is_load(aluop_i) | is_store(aluop_i);
    assign start       = (state == IDLE) && is_mem && !lane_misalign;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    mem_lane_align #(.DATA_W(DATA_W), .BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .op         (lane_op),
        .offset     (lane_off),
        .reg2       (reg2_i),
        .bus_data   (mem_data_i),
        .sel        (lane_sel),
        .store_data (lane_sdata),
        .load_data  (lane_ldata),
        .misalign   (lane_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (!mem_ack_i && timeout_hit) err <= 1'b1;
                end
                DONE:    cnt <= '0;
                default: begin
                    cnt <= '0;
                    err <= 1'b0;
                end
            endcase
        end
    end

    // Request latch on entry to ACCESS, load capture on ack
    always_ff @(posedge clk) begin
        if (start) begin
            addr_p1  <= mem_addr_i;
            sel_p1   <= lane_sel;
            sdata_p1 <= lane_sdata;
            op_p1    <= aluop_i;
            wd_p1    <= wd_i;
            wreg_p1  <= wreg_i;
        end
        if (in_access && mem_ack_i) ldata_p1 <= lane_ldata;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCESS;
            ACCESS:  if (mem_ack_i || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        mem_addr_o = '0;
        mem_we_o   = 1'b0;
        mem_sel_o  = '0;
        mem_data_o = '0;
        mem_ce_o   = 1'b0;
        stallreq_o = 1'b0;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        buserr_o   = 1'b0;
        badaddr_o  = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    wd_o    = wd_i;
                    wdata_o = wdata_i;
                    if (!is_mem) begin
                        wreg_o = wreg_i;
                    end else if (lane_misalign) begin
                        adel_o    = is_load(aluop_i);
                        ades_o    = is_store(aluop_i);
                        badaddr_o = mem_addr_i;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                ACCESS: begin
                    mem_ce_o   = 1'b1;
                    mem_we_o   = is_store(op_p1);
                    mem_addr_o = addr_p1 & ~ADDR_W'(NB - 1);
                    mem_sel_o  = sel_p1;
                    mem_data_o = sdata_p1;
                    stallreq_o = 1'b1;
                end
                DONE: begin
                    wd_o      = wd_p1;
                    wreg_o    = wreg_p1 & ~err & ~is_store(op_p1);
                    wdata_o   = ldata_p1;
                    buserr_o  = err;
                    badaddr_o = addr_p1;
                end
                default: ;
            endcase
        end
    end

endmodule
